// File: rtl/cdc_sync_pkg.sv
// Shared constants and the stage-count legality check for the cdc_sync synchronizer family.
package cdc_sync_pkg;

  localparam int unsigned CDC_SYNC_MIN_STAGES = 2;
  localparam int unsigned CDC_SYNC_DEF_STAGES = 2;

  // True when a requested chain depth gives adequate metastability settling.
  function automatic bit cdc_sync_stages_ok(input int unsigned stages);
    return stages >= CDC_SYNC_MIN_STAGES;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit synchronizer chain; edge outputs rise/fall/chg exist only when CDC_SYNC_EDGE_EN is defined.
module cdc_sync_bit
  import cdc_sync_pkg::*;
#(
  parameter int unsigned STAGES    = CDC_SYNC_DEF_STAGES,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
`ifdef CDC_SYNC_EDGE_EN
  ,
  output logic rise,
  output logic fall,
  output logic chg
`endif
);

  // Pure flop chain: only the reset mux sits in front of each stage, never data logic.
  (* ASYNC_REG = "TRUE", dont_retime = "true" *)
  logic [STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= {STAGES{RESET_VAL}};
    end else begin
      s <= {s[STAGES-2:0], din};
    end
  end

  assign dout = s[STAGES-1];

`ifdef CDC_SYNC_EDGE_EN
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= RESET_VAL;
    end else begin
      prev <= s[STAGES-1];
    end
  end

  // Decoded purely from registers so no path from din reaches the pulse outputs.
  assign rise = s[STAGES-1] & ~prev;
  assign fall = ~s[STAGES-1] & prev;
  assign chg  = s[STAGES-1] ^ prev;
`endif

endmodule

// File: rtl/cdc_sync.sv
// Multi-bit synchronizer: WIDTH independent cdc_sync_bit chains; CDC_SYNC_EDGE_EN adds rise/fall/chg pulses.
module cdc_sync
  import cdc_sync_pkg::*;
#(
  parameter int unsigned       WIDTH     = 1,
  parameter int unsigned       STAGES    = CDC_SYNC_DEF_STAGES,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
`ifdef CDC_SYNC_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] chg
`endif
);

  if (!cdc_sync_stages_ok(STAGES)) begin : g_bad_stages
    $error("cdc_sync: STAGES must be at least %0d", CDC_SYNC_MIN_STAGES);
  end

  // Bits are deliberately independent; no cross-bit coherency is implied.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    cdc_sync_bit #(
      .STAGES    (STAGES),
      .RESET_VAL (RESET_VAL[i])
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din[i]),
      .dout  (dout[i])
`ifdef CDC_SYNC_EDGE_EN
      ,
      .rise  (rise[i]),
      .fall  (fall[i]),
      .chg   (chg[i])
`endif
    );
  end

endmodule

// File: tb/tb_cdc_sync.sv
// Bench for cdc_sync: a 2-stage and a 3-stage instance share din/rst_n; a sample-history model checks every cycle.
module tb_cdc_sync;

  localparam logic [3:0] RV_A = 4'b1010;
  localparam logic [3:0] RV_B = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic [3:0] dout_a, dout_b;
`ifdef CDC_SYNC_EDGE_EN
  logic [3:0] rise_a, fall_a, chg_a, rise_b, fall_b, chg_b;
`endif

  always #5 clk = ~clk;

  cdc_sync #(.WIDTH(4), .STAGES(2), .RESET_VAL(RV_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout_a)
`ifdef CDC_SYNC_EDGE_EN
    , .rise(rise_a), .fall(fall_a), .chg(chg_a)
`endif
  );

  cdc_sync #(.WIDTH(4), .STAGES(3), .RESET_VAL(RV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout_b)
`ifdef CDC_SYNC_EDGE_EN
    , .rise(rise_b), .fall(fall_b), .chg(chg_b)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: history of what each rising edge saw (newest first).
  // After an edge, dout equals the din seen STAGES-1 edges earlier unless a reset edge lies in that window.
  logic [3:0] hd[$];
  bit         hr[$];
  bit         mdl_on = 1'b0;

  always @(posedge clk) begin
    hd.push_front(din);
    hr.push_front(!rst_n);
    if (hd.size() > 8) begin
      void'(hd.pop_back());
      void'(hr.pop_back());
    end
  end

  function automatic logic [3:0] m_dout(input int ago, input int stages, input logic [3:0] rv);
    for (int j = 0; j < stages; j++)
      if (hr[ago+j]) return rv;
    return hd[ago+stages-1];
  endfunction

  function automatic logic [3:0] m_prev(input int stages, input logic [3:0] rv);
    return hr[0] ? rv : m_dout(1, stages, rv);
  endfunction

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("model dout_a", dout_a, m_dout(0, 2, RV_A));
      chk("model dout_b", dout_b, m_dout(0, 3, RV_B));
`ifdef CDC_SYNC_EDGE_EN
      chk("model rise_a", rise_a, m_dout(0, 2, RV_A) & ~m_prev(2, RV_A));
      chk("model fall_a", fall_a, ~m_dout(0, 2, RV_A) & m_prev(2, RV_A));
      chk("model chg_a",  chg_a,  m_dout(0, 2, RV_A) ^ m_prev(2, RV_A));
      chk("model rise_b", rise_b, m_dout(0, 3, RV_B) & ~m_prev(3, RV_B));
      chk("model fall_b", fall_b, ~m_dout(0, 3, RV_B) & m_prev(3, RV_B));
      chk("model chg_b",  chg_b,  m_dout(0, 3, RV_B) ^ m_prev(3, RV_B));
`endif
    end
  end

  typedef struct {
    logic [3:0] din;
    int         cyc;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int pulses, run, runmax, dchg, bad, cnt, at;
    logic pd;

    tbl[0] = '{4'b1100, 1, 4'b0101, 4'b0101};
    tbl[1] = '{4'b1100, 1, 4'b1100, 4'b0101};
    tbl[2] = '{4'b1100, 1, 4'b1100, 4'b1100};
    tbl[3] = '{4'b0011, 2, 4'b0011, 4'b1100};
    tbl[4] = '{4'b1111, 4, 4'b1111, 4'b1111};
    tbl[5] = '{4'b0000, 3, 4'b0000, 4'b0000};

    // Reset hold with din away from RESET_VAL, then release.
    rst_n = 1'b0;
    din   = 4'b0101;
    step(3);
    chk("reset dout_a", dout_a, RV_A);
    chk("reset dout_b", dout_b, RV_B);
`ifdef CDC_SYNC_EDGE_EN
    chk("reset pulses_a", rise_a | fall_a | chg_a, 4'b0000);
`endif
    rst_n = 1'b1;
    step(1);
    chk("release+1 dout_a", dout_a, RV_A);
`ifdef CDC_SYNC_EDGE_EN
    chk("release+1 pulses_a", rise_a | fall_a | chg_a, 4'b0000);
`endif
    step(1);
    chk("release+2 dout_a", dout_a, 4'b0101);
`ifdef CDC_SYNC_EDGE_EN
    chk("release+2 rise_a", rise_a, 4'b0101);
    chk("release+2 fall_a", fall_a, 4'b1010);
    chk("release+2 chg_a",  chg_a,  4'b1111);
`endif
    step(1);
    chk("release+3 dout_b", dout_b, 4'b0101);
`ifdef CDC_SYNC_EDGE_EN
    chk("release+3 pulses_a", rise_a | fall_a | chg_a, 4'b0000);
    chk("release+3 rise_b", rise_b, 4'b0101);
`endif
    mdl_on = 1'b1;

    // Table of level changes with differing hold times.
    for (int i = 0; i < 6; i++) begin
      din = tbl[i].din;
      step(tbl[i].cyc);
      chk($sformatf("vec%0d dout_a", i), dout_a, tbl[i].exp_a);
      chk($sformatf("vec%0d dout_b", i), dout_b, tbl[i].exp_b);
    end

    // Three-stage latency: new value visible on the third capture edge.
    step(2);
    din = 4'b0001;
    step(1); chk("lat3 edge N dout_b",   dout_b, 4'b0000);
    step(1); chk("lat3 edge N+1 dout_b", dout_b, 4'b0000);
    step(1); chk("lat3 edge N+2 dout_b", dout_b, 4'b0001);
`ifdef CDC_SYNC_EDGE_EN
    chk("lat3 edge N+2 rise_b", rise_b, 4'b0001);
    step(1); chk("lat3 edge N+3 rise_b", rise_b, 4'b0000);
`endif

    // Toggle events on bit 0, spaced 4 cycles.
    pulses = 0; run = 0; runmax = 0; dchg = 0;
    pd = dout_a[0];
    for (int c = 0; c < 24; c++) begin
      if (c % 4 == 0 && c < 20) din[0] = ~din[0];
      step(1);
      if (dout_a[0] !== pd) dchg++;
      pd = dout_a[0];
`ifdef CDC_SYNC_EDGE_EN
      if (chg_a[0]) begin pulses++; run++; end else run = 0;
      if (run > runmax) runmax = run;
`endif
    end
    chk_int("toggle dout_a[0] changes", dchg, 5);
`ifdef CDC_SYNC_EDGE_EN
    chk_int("toggle chg_a[0] pulses", pulses, 5);
    chk_int("toggle chg_a[0] width", runmax, 1);
`endif

    // Independence: bit 1 toggles while bit 0 holds 1.
    din[0] = 1'b1;
    step(4);
    bad = 0; dchg = 0;
    pd = dout_a[1];
    for (int c = 0; c < 20; c++) begin
      if (c % 3 == 0 && c < 15) din[1] = ~din[1];
      din[3:2] = 2'($urandom);
      step(1);
      if (dout_a[0] !== 1'b1) bad++;
`ifdef CDC_SYNC_EDGE_EN
      if (chg_a[0] !== 1'b0) bad++;
`endif
      if (dout_a[1] !== pd) dchg++;
      pd = dout_a[1];
    end
    chk_int("indep bit0 disturbances", bad, 0);
    chk_int("indep bit1 changes", dchg, 5);

    // Reset lands while a 0->1 on bit 0 is in flight.
    din = 4'b0000;
    step(4);
    din = 4'b0001;
    step(1);
    rst_n = 1'b0;
    step(2);
    chk("midrst dout_a", dout_a, RV_A);
`ifdef CDC_SYNC_EDGE_EN
    chk("midrst rise_a", rise_a, 4'b0000);
`endif
    rst_n = 1'b1;
    cnt = 0; at = -1;
    for (int c = 0; c < 6; c++) begin
      step(1);
`ifdef CDC_SYNC_EDGE_EN
      if (rise_a[0]) begin cnt++; at = c; end
`else
      if (dout_a[0] && at < 0) begin cnt++; at = c; end
`endif
    end
    chk_int("midrst bit0 event count", cnt, 1);
    chk_int("midrst bit0 event cycle", at, 1);

    // Randomized din with occasional resets, checked by the model.
    for (int c = 0; c < 400; c++) begin
      din   = 4'($urandom);
      rst_n = ($urandom_range(0, 40) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
